// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write side.
//   W_DEF / D_DEF / LQ_DEF : default data width, register pointer width and
//                            outstanding-load queue depth.
//   wb_req_t               : one register-file write request at default widths.
package rf_pkg;

  localparam int W_DEF  = 8;
  localparam int D_DEF  = 3;
  localparam int LQ_DEF = 2;

  typedef struct packed {
    logic [D_DEF-1:0] addr;
    logic [W_DEF-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/ld_tag_fifo.sv
// Outstanding-load destination FIFO.
//   CLK, Reset           : clock, synchronous active-high reset
//   push / push_addr     : record a newly issued load destination (caller gates with !full)
//   pop                  : retire the oldest destination (caller gates with !empty)
//   full, empty, head    : occupancy flags and oldest destination
//   match_addr_0/1/2     : pointers to compare against every valid entry
//   match_0/1/2          : 1 when a valid entry equals the pointer; register 0 never matches
module ld_tag_fifo
  import rf_pkg::*;
#(
  parameter int D  = D_DEF,
  parameter int LQ = LQ_DEF
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         push,
  input  logic [D-1:0] push_addr,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [D-1:0] head,
  input  logic [D-1:0] match_addr_0,
  input  logic [D-1:0] match_addr_1,
  input  logic [D-1:0] match_addr_2,
  output logic         match_0,
  output logic         match_1,
  output logic         match_2
);

  localparam int PW = (LQ > 1) ? $clog2(LQ) : 1;

  logic [D-1:0]  tag_r [LQ];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW:0]   count_r;
  logic [LQ-1:0] valid_s;

  assign full  = (count_r == (PW+1)'(LQ));
  assign empty = (count_r == {(PW+1){1'b0}});
  assign head  = tag_r[rd_ptr_r];

  // Mark entries lying between the read pointer and count; LQ is a power of 2 so
  // the pointer subtraction wraps naturally.
  always_comb begin
    valid_s = {LQ{1'b0}};
    for (int i = 0; i < LQ; i++) begin
      if ({1'b0, PW'(i) - rd_ptr_r} < count_r) begin
        valid_s[i] = 1'b1;
      end else begin
        valid_s[i] = 1'b0;
      end
    end
  end

  // Compare the three pointers against all valid, non-zero entries.
  always_comb begin
    match_0 = 1'b0;
    match_1 = 1'b0;
    match_2 = 1'b0;
    for (int i = 0; i < LQ; i++) begin
      if (valid_s[i] && (tag_r[i] != {D{1'b0}})) begin
        match_0 = match_0 | (tag_r[i] == match_addr_0);
        match_1 = match_1 | (tag_r[i] == match_addr_1);
        match_2 = match_2 | (tag_r[i] == match_addr_2);
      end else begin
        match_0 = match_0;
        match_1 = match_1;
        match_2 = match_2;
      end
    end
  end

  // Pointer, count and storage update.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
      for (int i = 0; i < LQ; i++) begin
        tag_r[i] <= {D{1'b0}};
      end
    end else begin
      if (push) begin
        tag_r[wr_ptr_r] <= push_addr;
        wr_ptr_r        <= wr_ptr_r + PW'(1'b1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + (PW+1)'(1'b1);
        2'b01:   count_r <= count_r - (PW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write-port driver: merges ALU results and in-order load returns.
//   CLK, Reset                     : clock, synchronous active-high reset
//   Alu_valid/Alu_ready/Alu_addr/Alu_data : ALU result handshake
//   Ld_issue/Ld_issue_addr/Ld_issue_ready : record an outstanding load destination
//   Ld_valid/Ld_data               : data for the oldest outstanding load
//   Chk_addr_0/1, Chk_busy_0/1     : decode hazard check against outstanding loads
//   Reg_write_en/address/data      : registered register-file write port
//   Err                            : sticky protocol error (overflow issue / underflow return)
module reg_writeback
  import rf_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int D  = D_DEF,
  parameter int LQ = LQ_DEF
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         Alu_valid,
  output logic         Alu_ready,
  input  logic [D-1:0] Alu_addr,
  input  logic [W-1:0] Alu_data,
  input  logic         Ld_issue,
  input  logic [D-1:0] Ld_issue_addr,
  output logic         Ld_issue_ready,
  input  logic         Ld_valid,
  input  logic [W-1:0] Ld_data,
  input  logic [D-1:0] Chk_addr_0,
  input  logic [D-1:0] Chk_addr_1,
  output logic         Chk_busy_0,
  output logic         Chk_busy_1,
  output logic         Reg_write_en,
  output logic [D-1:0] Reg_write_address,
  output logic [W-1:0] Reg_write_data,
  output logic         Err
);

  logic         full_s;
  logic         empty_s;
  logic [D-1:0] head_s;
  logic         alu_hit_s;
  logic         push_s;
  logic         pop_s;
  logic         alu_acc_s;

  logic         sel_v_s;
  logic [D-1:0] sel_addr_s;
  logic [W-1:0] sel_data_s;
  logic         skid_load_s;
  logic         skid_drain_s;

  logic         skid_v_r;
  logic [D-1:0] skid_addr_r;
  logic [W-1:0] skid_data_r;
  logic         en_r;
  logic [D-1:0] addr_r;
  logic [W-1:0] data_r;
  logic         err_r;

  // Ready flags look only at registered state plus the offered address, never at Alu_valid.
  assign Alu_ready      = !skid_v_r && !alu_hit_s;
  assign Ld_issue_ready = !full_s;
  assign alu_acc_s      = Alu_valid && Alu_ready;
  assign push_s         = Ld_issue && !full_s;
  assign pop_s          = Ld_valid && !empty_s;

  assign Reg_write_en      = en_r;
  assign Reg_write_address = addr_r;
  assign Reg_write_data    = data_r;
  assign Err               = err_r;

  ld_tag_fifo #(
    .D  (D),
    .LQ (LQ)
  ) u_ld_tag_fifo (
    .CLK          (CLK),
    .Reset        (Reset),
    .push         (push_s),
    .push_addr    (Ld_issue_addr),
    .pop          (pop_s),
    .full         (full_s),
    .empty        (empty_s),
    .head         (head_s),
    .match_addr_0 (Chk_addr_0),
    .match_addr_1 (Chk_addr_1),
    .match_addr_2 (Alu_addr),
    .match_0      (Chk_busy_0),
    .match_1      (Chk_busy_1),
    .match_2      (alu_hit_s)
  );

  // Write-port arbitration: load return, then skid, then fresh ALU result.
  // A fresh ALU result that loses to a load parks in the skid; the skid can only be
  // empty at that point because Alu_ready requires it.
  always_comb begin
    sel_v_s      = 1'b0;
    sel_addr_s   = {D{1'b0}};
    sel_data_s   = {W{1'b0}};
    skid_load_s  = 1'b0;
    skid_drain_s = 1'b0;
    if (pop_s) begin
      sel_v_s     = 1'b1;
      sel_addr_s  = head_s;
      sel_data_s  = Ld_data;
      skid_load_s = alu_acc_s;
    end else if (skid_v_r) begin
      sel_v_s      = 1'b1;
      sel_addr_s   = skid_addr_r;
      sel_data_s   = skid_data_r;
      skid_drain_s = 1'b1;
    end else if (alu_acc_s) begin
      sel_v_s    = 1'b1;
      sel_addr_s = Alu_addr;
      sel_data_s = Alu_data;
    end else begin
      sel_v_s = 1'b0;
    end
  end

  // Skid register, write-port registers and sticky error flag.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      skid_v_r    <= 1'b0;
      skid_addr_r <= {D{1'b0}};
      skid_data_r <= {W{1'b0}};
      en_r        <= 1'b0;
      addr_r      <= {D{1'b0}};
      data_r      <= {W{1'b0}};
      err_r       <= 1'b0;
    end else begin
      if (skid_load_s) begin
        skid_v_r    <= 1'b1;
        skid_addr_r <= Alu_addr;
        skid_data_r <= Alu_data;
      end else if (skid_drain_s) begin
        skid_v_r <= 1'b0;
      end
      // Writes to register 0 are consumed silently: no strobe, port holds its last value.
      if (sel_v_s && (sel_addr_s != {D{1'b0}})) begin
        en_r   <= 1'b1;
        addr_r <= sel_addr_s;
        data_r <= sel_data_s;
      end else begin
        en_r <= 1'b0;
      end
      err_r <= err_r | (Ld_issue && full_s) | (Ld_valid && empty_s);
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;

  localparam int LQ = 2;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic       Alu_valid = 1'b0;
  logic       Alu_ready;
  logic [2:0] Alu_addr = 3'd0;
  logic [7:0] Alu_data = 8'd0;
  logic       Ld_issue = 1'b0;
  logic [2:0] Ld_issue_addr = 3'd0;
  logic       Ld_issue_ready;
  logic       Ld_valid = 1'b0;
  logic [7:0] Ld_data = 8'd0;
  logic [2:0] Chk_addr_0 = 3'd0;
  logic [2:0] Chk_addr_1 = 3'd0;
  logic       Chk_busy_0;
  logic       Chk_busy_1;
  logic       Reg_write_en;
  logic [2:0] Reg_write_address;
  logic [7:0] Reg_write_data;
  logic       Err;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: list of outstanding destinations, optional parked ALU result.
  int         m_q[$];
  bit         m_skid_v = 1'b0;
  int         m_skid_a = 0;
  logic [7:0] m_skid_d = 8'd0;
  logic       m_err = 1'b0;
  logic       m_en = 1'b0;
  logic [2:0] m_addr = 3'd0;
  logic [7:0] m_data = 8'd0;
  logic       m_alu_ready, m_iss_ready, m_busy0, m_busy1;

  // Values observed just before the clock edge.
  logic       obs_alu_ready, obs_iss_ready, obs_busy0, obs_busy1;

  reg_writeback dut (
    .CLK               (CLK),
    .Reset             (Reset),
    .Alu_valid         (Alu_valid),
    .Alu_ready         (Alu_ready),
    .Alu_addr          (Alu_addr),
    .Alu_data          (Alu_data),
    .Ld_issue          (Ld_issue),
    .Ld_issue_addr     (Ld_issue_addr),
    .Ld_issue_ready    (Ld_issue_ready),
    .Ld_valid          (Ld_valid),
    .Ld_data           (Ld_data),
    .Chk_addr_0        (Chk_addr_0),
    .Chk_addr_1        (Chk_addr_1),
    .Chk_busy_0        (Chk_busy_0),
    .Chk_busy_1        (Chk_busy_1),
    .Reg_write_en      (Reg_write_en),
    .Reg_write_address (Reg_write_address),
    .Reg_write_data    (Reg_write_data),
    .Err               (Err)
  );

  always #5 CLK = ~CLK;

  function automatic bit pending(input int a);
    if (a == 0) return 1'b0;
    foreach (m_q[i]) if (m_q[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one cycle of inputs, capture pre-edge outputs, advance the model, cross the edge.
  task automatic apply(input logic rst, input logic av, input logic [2:0] aa, input logic [7:0] ad,
                       input logic iss, input logic [2:0] ia, input logic lv, input logic [7:0] ldd,
                       input logic [2:0] c0, input logic [2:0] c1);
    bit w_v;
    int w_a;
    logic [7:0] w_d;
    bit acc, full, empty;
    Reset = rst; Alu_valid = av; Alu_addr = aa; Alu_data = ad;
    Ld_issue = iss; Ld_issue_addr = ia; Ld_valid = lv; Ld_data = ldd;
    Chk_addr_0 = c0; Chk_addr_1 = c1;
    #1;
    obs_alu_ready = Alu_ready; obs_iss_ready = Ld_issue_ready;
    obs_busy0 = Chk_busy_0; obs_busy1 = Chk_busy_1;
    m_alu_ready = !m_skid_v && !pending(int'(aa));
    m_iss_ready = (m_q.size() < LQ);
    m_busy0 = pending(int'(c0));
    m_busy1 = pending(int'(c1));
    if (rst) begin
      m_q.delete(); m_skid_v = 1'b0; m_err = 1'b0;
      m_en = 1'b0; m_addr = 3'd0; m_data = 8'd0;
    end else begin
      w_v = 1'b0; w_a = 0; w_d = 8'd0;
      acc = av && m_alu_ready;
      full = (m_q.size() >= LQ);
      empty = (m_q.size() == 0);
      if (lv && !empty) begin
        w_v = 1'b1; w_a = m_q.pop_front(); w_d = ldd;
        if (acc) begin m_skid_v = 1'b1; m_skid_a = int'(aa); m_skid_d = ad; end
      end else if (m_skid_v) begin
        w_v = 1'b1; w_a = m_skid_a; w_d = m_skid_d; m_skid_v = 1'b0;
      end else if (acc) begin
        w_v = 1'b1; w_a = int'(aa); w_d = ad;
      end
      if (lv && empty) m_err = 1'b1;
      if (iss) begin
        if (full) m_err = 1'b1;
        else m_q.push_back(int'(ia));
      end
      m_en = w_v && (w_a != 0);
      if (m_en) begin m_addr = w_a[2:0]; m_data = w_d; end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input logic [2:0] c0, input logic [2:0] c1);
    apply(1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b0, 8'd0, c0, c1);
  endtask

  task automatic do_reset();
    apply(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b0, 8'd0, 3'd0, 3'd0);
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
    n_vec++; if (Reg_write_en !== 1'b0) begin n_err++; $display("FAIL reset_en got=%b exp=0", Reg_write_en); end
    n_vec++; if (Reg_write_address !== 3'd0) begin n_err++; $display("FAIL reset_addr got=%0d exp=0", Reg_write_address); end
    n_vec++; if (Reg_write_data !== 8'd0) begin n_err++; $display("FAIL reset_data got=%h exp=00", Reg_write_data); end
    n_vec++; if (Err !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", Err); end
    idle(3'd1, 3'd2);
    n_vec++; if (obs_alu_ready !== 1'b1) begin n_err++; $display("FAIL reset_alu_ready got=%b exp=1", obs_alu_ready); end
    n_vec++; if (obs_iss_ready !== 1'b1) begin n_err++; $display("FAIL reset_iss_ready got=%b exp=1", obs_iss_ready); end
    n_vec++; if ({obs_busy0, obs_busy1} !== 2'b00) begin n_err++; $display("FAIL reset_busy got=%b%b exp=00", obs_busy0, obs_busy1); end
  endtask

  task automatic test_alu_only();
    apply(1'b0, 1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 1'b0, 8'd0, 3'd0, 3'd0);
    n_vec++; if (obs_alu_ready !== 1'b1) begin n_err++; $display("FAIL alu_ready got=%b exp=1", obs_alu_ready); end
    n_vec++; if ({Reg_write_en, Reg_write_address, Reg_write_data} !== {1'b1, 3'd3, 8'h5A})
      begin n_err++; $display("FAIL alu_write got=%b/%0d/%h exp=1/3/5a", Reg_write_en, Reg_write_address, Reg_write_data); end
    idle(3'd0, 3'd0);
    n_vec++; if (Reg_write_en !== 1'b0) begin n_err++; $display("FAIL alu_idle_en got=%b exp=0", Reg_write_en); end
    n_vec++; if ({Reg_write_address, Reg_write_data} !== {3'd3, 8'h5A})
      begin n_err++; $display("FAIL alu_hold got=%0d/%h exp=3/5a", Reg_write_address, Reg_write_data); end
  endtask

  task automatic test_collision();
    do_reset();
    apply(1'b0, 1'b0, 3'd0, 8'd0, 1'b1, 3'd2, 1'b0, 8'd0, 3'd2, 3'd0);
    idle(3'd2, 3'd4);
    n_vec++; if ({obs_busy0, obs_busy1} !== 2'b10) begin n_err++; $display("FAIL coll_busy got=%b%b exp=10", obs_busy0, obs_busy1); end
    apply(1'b0, 1'b1, 3'd4, 8'h22, 1'b0, 3'd0, 1'b1, 8'h11, 3'd2, 3'd0);
    n_vec++; if (obs_alu_ready !== 1'b1) begin n_err++; $display("FAIL coll_ready0 got=%b exp=1", obs_alu_ready); end
    n_vec++; if ({Reg_write_en, Reg_write_address, Reg_write_data} !== {1'b1, 3'd2, 8'h11})
      begin n_err++; $display("FAIL coll_ld got=%b/%0d/%h exp=1/2/11", Reg_write_en, Reg_write_address, Reg_write_data); end
    apply(1'b0, 1'b1, 3'd5, 8'h99, 1'b0, 3'd0, 1'b0, 8'd0, 3'd2, 3'd0);
    n_vec++; if (obs_alu_ready !== 1'b0) begin n_err++; $display("FAIL coll_ready1 got=%b exp=0", obs_alu_ready); end
    n_vec++; if (obs_busy0 !== 1'b0) begin n_err++; $display("FAIL coll_busy_clr got=%b exp=0", obs_busy0); end
    n_vec++; if ({Reg_write_en, Reg_write_address, Reg_write_data} !== {1'b1, 3'd4, 8'h22})
      begin n_err++; $display("FAIL coll_skid got=%b/%0d/%h exp=1/4/22", Reg_write_en, Reg_write_address, Reg_write_data); end
    idle(3'd0, 3'd0);
    n_vec++; if (obs_alu_ready !== 1'b1) begin n_err++; $display("FAIL coll_ready2 got=%b exp=1", obs_alu_ready); end
    n_vec++; if (Reg_write_en !== 1'b0) begin n_err++; $display("FAIL coll_after_en got=%b exp=0", Reg_write_en); end
  endtask

  task automatic test_queue_full();
    do_reset();
    apply(1'b0, 1'b0, 3'd0, 8'd0, 1'b1, 3'd5, 1'b0, 8'd0, 3'd5, 3'd6);
    apply(1'b0, 1'b0, 3'd0, 8'd0, 1'b1, 3'd6, 1'b0, 8'd0, 3'd5, 3'd6);
    n_vec++; if (obs_iss_ready !== 1'b1) begin n_err++; $display("FAIL qf_ready_one got=%b exp=1", obs_iss_ready); end
    idle(3'd5, 3'd6);
    n_vec++; if (obs_iss_ready !== 1'b0) begin n_err++; $display("FAIL qf_ready_full got=%b exp=0", obs_iss_ready); end
    n_vec++; if ({obs_busy0, obs_busy1} !== 2'b11) begin n_err++; $display("FAIL qf_busy got=%b%b exp=11", obs_busy0, obs_busy1); end
    n_vec++; if (Err !== 1'b0) begin n_err++; $display("FAIL qf_err_pre got=%b exp=0", Err); end
    apply(1'b0, 1'b0, 3'd0, 8'd0, 1'b1, 3'd7, 1'b0, 8'd0, 3'd5, 3'd7);
    n_vec++; if (Err !== 1'b1) begin n_err++; $display("FAIL qf_err got=%b exp=1", Err); end
    apply(1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b1, 8'hA1, 3'd5, 3'd7);
    n_vec++; if (obs_busy1 !== 1'b0) begin n_err++; $display("FAIL qf_dropped_busy got=%b exp=0", obs_busy1); end
    n_vec++; if ({Reg_write_en, Reg_write_address, Reg_write_data} !== {1'b1, 3'd5, 8'hA1})
      begin n_err++; $display("FAIL qf_ret0 got=%b/%0d/%h exp=1/5/a1", Reg_write_en, Reg_write_address, Reg_write_data); end
    apply(1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b1, 8'hA2, 3'd5, 3'd6);
    n_vec++; if ({obs_busy0, obs_busy1} !== 2'b01) begin n_err++; $display("FAIL qf_busy_mid got=%b%b exp=01", obs_busy0, obs_busy1); end
    n_vec++; if ({Reg_write_en, Reg_write_address, Reg_write_data} !== {1'b1, 3'd6, 8'hA2})
      begin n_err++; $display("FAIL qf_ret1 got=%b/%0d/%h exp=1/6/a2", Reg_write_en, Reg_write_address, Reg_write_data); end
    idle(3'd5, 3'd6);
    n_vec++; if ({obs_busy0, obs_busy1, obs_iss_ready} !== 3'b001) begin n_err++; $display("FAIL qf_drained got=%b%b%b exp=001", obs_busy0, obs_busy1, obs_iss_ready); end
    n_vec++; if (Err !== 1'b1) begin n_err++; $display("FAIL qf_err_sticky got=%b exp=1", Err); end
  endtask

  task automatic test_waw();
    do_reset();
    apply(1'b0, 1'b0, 3'd0, 8'd0, 1'b1, 3'd1, 1'b0, 8'd0, 3'd0, 3'd0);
    for (int k = 0; k < 2; k++) begin
      apply(1'b0, 1'b1, 3'd1, 8'h33, 1'b0, 3'd0, 1'b0, 8'd0, 3'd0, 3'd0);
      n_vec++; if (obs_alu_ready !== 1'b0) begin n_err++; $display("FAIL waw_ready%0d got=%b exp=0", k, obs_alu_ready); end
      n_vec++; if (Reg_write_en !== 1'b0) begin n_err++; $display("FAIL waw_en%0d got=%b exp=0", k, Reg_write_en); end
    end
    apply(1'b0, 1'b1, 3'd1, 8'h33, 1'b0, 3'd0, 1'b1, 8'h44, 3'd0, 3'd0);
    n_vec++; if (obs_alu_ready !== 1'b0) begin n_err++; $display("FAIL waw_ready_ret got=%b exp=0", obs_alu_ready); end
    n_vec++; if ({Reg_write_en, Reg_write_address, Reg_write_data} !== {1'b1, 3'd1, 8'h44})
      begin n_err++; $display("FAIL waw_ld got=%b/%0d/%h exp=1/1/44", Reg_write_en, Reg_write_address, Reg_write_data); end
    apply(1'b0, 1'b1, 3'd1, 8'h33, 1'b0, 3'd0, 1'b0, 8'd0, 3'd0, 3'd0);
    n_vec++; if (obs_alu_ready !== 1'b1) begin n_err++; $display("FAIL waw_ready_free got=%b exp=1", obs_alu_ready); end
    n_vec++; if ({Reg_write_en, Reg_write_address, Reg_write_data} !== {1'b1, 3'd1, 8'h33})
      begin n_err++; $display("FAIL waw_alu got=%b/%0d/%h exp=1/1/33", Reg_write_en, Reg_write_address, Reg_write_data); end
  endtask

  task automatic test_reg_zero();
    do_reset();
    apply(1'b0, 1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 1'b0, 8'd0, 3'd0, 3'd0);
    n_vec++; if (obs_alu_ready !== 1'b1) begin n_err++; $display("FAIL r0_ready got=%b exp=1", obs_alu_ready); end
    n_vec++; if (Reg_write_en !== 1'b0) begin n_err++; $display("FAIL r0_alu_en got=%b exp=0", Reg_write_en); end
    apply(1'b0, 1'b0, 3'd0, 8'd0, 1'b1, 3'd0, 1'b0, 8'd0, 3'd0, 3'd0);
    idle(3'd0, 3'd0);
    n_vec++; if ({obs_busy0, obs_iss_ready} !== 2'b01) begin n_err++; $display("FAIL r0_slot got=%b%b exp=01", obs_busy0, obs_iss_ready); end
    apply(1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b1, 8'h77, 3'd0, 3'd0);
    n_vec++; if ({Reg_write_en, Err} !== 2'b00) begin n_err++; $display("FAIL r0_ld got=%b%b exp=00", Reg_write_en, Err); end
    apply(1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b1, 8'h78, 3'd0, 3'd0);
    n_vec++; if ({Reg_write_en, Err} !== 2'b01) begin n_err++; $display("FAIL r0_underflow got=%b%b exp=01", Reg_write_en, Err); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    apply(1'b0, 1'b0, 3'd0, 8'd0, 1'b1, 3'd3, 1'b0, 8'd0, 3'd0, 3'd0);
    apply(1'b0, 1'b1, 3'd6, 8'h66, 1'b1, 3'd4, 1'b1, 8'h55, 3'd0, 3'd0);
    apply(1'b1, 1'b1, 3'd7, 8'h12, 1'b1, 3'd5, 1'b1, 8'h34, 3'd4, 3'd0);
    n_vec++; if ({obs_alu_ready, obs_busy0} !== 2'b01) begin n_err++; $display("FAIL mid_pre got=%b%b exp=01", obs_alu_ready, obs_busy0); end
    n_vec++; if ({Reg_write_en, Err} !== 2'b00) begin n_err++; $display("FAIL mid_rst got=%b%b exp=00", Reg_write_en, Err); end
    idle(3'd4, 3'd5);
    n_vec++; if ({obs_alu_ready, obs_iss_ready, obs_busy0, obs_busy1} !== 4'b1100)
      begin n_err++; $display("FAIL mid_clear got=%b%b%b%b exp=1100", obs_alu_ready, obs_iss_ready, obs_busy0, obs_busy1); end
    n_vec++; if (Reg_write_en !== 1'b0) begin n_err++; $display("FAIL mid_skid_drop got=%b exp=0", Reg_write_en); end
    apply(1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b1, 8'h56, 3'd0, 3'd0);
    n_vec++; if ({Reg_write_en, Err} !== 2'b01) begin n_err++; $display("FAIL mid_late_ld got=%b%b exp=01", Reg_write_en, Err); end
  endtask

  task automatic test_random();
    logic rst, av, iss, lv;
    logic [2:0] aa, ia, c0, c1;
    logic [7:0] ad, ldd;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      av  = $urandom_range(0, 1);
      aa  = 3'($urandom_range(0, 7));
      ad  = 8'($urandom);
      iss = ($urandom_range(0, 2) == 0);
      ia  = 3'($urandom_range(0, 7));
      lv  = (m_q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 40) == 0);
      ldd = 8'($urandom);
      c0  = 3'($urandom_range(0, 7));
      c1  = (m_q.size() > 0 && $urandom_range(0, 1) == 1) ? 3'(m_q[0]) : 3'($urandom_range(0, 7));
      apply(rst, av, aa, ad, iss, ia, lv, ldd, c0, c1);
      n_vec++; if (obs_alu_ready !== m_alu_ready) begin n_err++; $display("FAIL rnd_alu_ready cyc=%0d got=%b exp=%b", n, obs_alu_ready, m_alu_ready); end
      n_vec++; if (obs_iss_ready !== m_iss_ready) begin n_err++; $display("FAIL rnd_iss_ready cyc=%0d got=%b exp=%b", n, obs_iss_ready, m_iss_ready); end
      n_vec++; if ({obs_busy0, obs_busy1} !== {m_busy0, m_busy1}) begin n_err++; $display("FAIL rnd_busy cyc=%0d got=%b%b exp=%b%b", n, obs_busy0, obs_busy1, m_busy0, m_busy1); end
      n_vec++; if (Reg_write_en !== m_en) begin n_err++; $display("FAIL rnd_en cyc=%0d got=%b exp=%b", n, Reg_write_en, m_en); end
      n_vec++; if (Err !== m_err) begin n_err++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", n, Err, m_err); end
      if (m_en) begin
        n_vec++; if ({Reg_write_address, Reg_write_data} !== {m_addr, m_data})
          begin n_err++; $display("FAIL rnd_write cyc=%0d got=%0d/%h exp=%0d/%h", n, Reg_write_address, Reg_write_data, m_addr, m_data); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_collision();
    test_queue_full();
    test_waw();
    test_reg_zero();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
